pattern_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; successor to the fixed 3-state Mealy detector.

---
 rtl/pattern_detector_param_if.sv | 39 +++
 rtl/pattern_detector_param.sv | 111 +++++++++++
 tb/tb_pattern_detector_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pattern_detector_param_if.sv
// Serial data, configuration and result bundle for pattern_detector_param.
// cfg_mask exists only when PATTERN_MASK_EN is defined.
interface pattern_detector_param_if #(
   parameter int unsigned PATTERN_LEN = 4,
   parameter int unsigned COUNT_W     = 8
);
   logic                   din;
   logic                   din_valid;
   logic                   overlap_en;
   logic                   cfg_load;
   logic [PATTERN_LEN-1:0] cfg_pattern;
`ifdef PATTERN_MASK_EN
   logic [PATTERN_LEN-1:0] cfg_mask;
`endif
   logic                   cnt_clr;
   logic                   detect;
   logic [COUNT_W-1:0]     match_count;
   logic                   armed;

   // Stimulus side: drives data and configuration, observes results.
   modport master (
      output din, din_valid, overlap_en, cfg_load, cfg_pattern,
`ifdef PATTERN_MASK_EN
      output cfg_mask,
`endif
      output cnt_clr,
      input  detect, match_count, armed
   );

   // Detector side.
   modport slave (
      input  din, din_valid, overlap_en, cfg_load, cfg_pattern,
`ifdef PATTERN_MASK_EN
      input  cfg_mask,
`endif
      input  cnt_clr,
      output detect, match_count, armed
   );
endinterface

// File: rtl/pattern_detector_param.sv
// Parametrised serial bit-pattern detector with run-time reload, overlap control and a
// saturating match counter. Optional don't-care mask enabled by `define PATTERN_MASK_EN.
module pattern_detector_param #(
   parameter int unsigned              PATTERN_LEN   = 4,
   parameter logic [PATTERN_LEN-1:0]   RESET_PATTERN = PATTERN_LEN'(4'b1011),
   parameter int unsigned              COUNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   pattern_detector_param_if.slave  bus
);

   localparam int unsigned FILL_W = $clog2(PATTERN_LEN + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_LEN);
   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

   logic [PATTERN_LEN-1:0] history_q, history_n;
   logic [PATTERN_LEN-1:0] pattern_q, pattern_n;
   logic [FILL_W-1:0]      fill_q, fill_n;
   logic [COUNT_W-1:0]     count_q, count_n;
   logic                   detect_q, detect_n;
   logic                   armed_q, armed_n;
`ifdef PATTERN_MASK_EN
   logic [PATTERN_LEN-1:0] mask_q, mask_n;
`endif

   logic [PATTERN_LEN-1:0] shifted_c;
   logic [FILL_W-1:0]      fill_inc_c;
   logic                   compare_c;
   logic                   hit_c;

   // Next-state and hit evaluation for the bit presented this cycle.
   always_comb begin
      history_n  = history_q;
      pattern_n  = pattern_q;
      fill_n     = fill_q;
      count_n    = count_q;
      detect_n   = 1'b0;
`ifdef PATTERN_MASK_EN
      mask_n     = mask_q;
`endif

      shifted_c  = {history_q[PATTERN_LEN-2:0], bus.din};
      fill_inc_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
`ifdef PATTERN_MASK_EN
      compare_c  = ((shifted_c ^ pattern_q) & mask_q) == '0;
`else
      compare_c  = (shifted_c == pattern_q);
`endif
      // A bit coinciding with cfg_load is discarded, so it can never hit.
      hit_c = bus.din_valid && !bus.cfg_load && (fill_inc_c == FILL_FULL) && compare_c;

      if (bus.cfg_load) begin
         pattern_n = bus.cfg_pattern;
`ifdef PATTERN_MASK_EN
         mask_n    = bus.cfg_mask;
`endif
         history_n = '0;
         fill_n    = '0;
      end else if (bus.din_valid) begin
         history_n = shifted_c;
         fill_n    = fill_inc_c;
         if (hit_c) begin
            detect_n = 1'b1;
            // Non-overlapping mode restarts the window so no matched bit is reused.
            if (!bus.overlap_en) begin
               fill_n = '0;
            end
         end
      end

      // Clear wins over a same-cycle hit; detect still pulses.
      if (bus.cnt_clr) begin
         count_n = '0;
      end else if (hit_c && (count_q != COUNT_MAX)) begin
         count_n = count_q + COUNT_W'(1);
      end

      armed_n = (fill_n == FILL_FULL);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         history_q <= '0;
         pattern_q <= RESET_PATTERN;
         fill_q    <= '0;
         count_q   <= '0;
         detect_q  <= 1'b0;
         armed_q   <= 1'b0;
`ifdef PATTERN_MASK_EN
         mask_q    <= '1;
`endif
      end else begin
         history_q <= history_n;
         pattern_q <= pattern_n;
         fill_q    <= fill_n;
         count_q   <= count_n;
         detect_q  <= detect_n;
         armed_q   <= armed_n;
`ifdef PATTERN_MASK_EN
         mask_q    <= mask_n;
`endif
      end
   end

   assign bus.detect      = detect_q;
   assign bus.match_count = count_q;
   assign bus.armed       = armed_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed table-driven bench for pattern_detector_param at default parameters
// (PATTERN_LEN=4, pattern 1011, COUNT_W=8); mask sequence runs when PATTERN_MASK_EN is defined.
module tb_pattern_detector_param;

   logic clk;
   logic reset;

   pattern_detector_param_if #(.PATTERN_LEN(4), .COUNT_W(8)) bus ();

   pattern_detector_param #(
      .PATTERN_LEN  (4),
      .RESET_PATTERN(4'b1011),
      .COUNT_W      (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       din;
      logic       valid;
      logic       ov;
      logic       ld;
      logic       clr;
      logic [3:0] pat;
      logic [3:0] msk;
      logic       ed;
      logic [7:0] ec;
      logic       ea;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(logic rst, logic din, logic valid, logic ov, logic ld,
                               logic clr, logic [3:0] pat, logic ed, logic [7:0] ec, logic ea);
      vec_t v;
      v.rst = rst; v.din = din; v.valid = valid; v.ov = ov; v.ld = ld; v.clr = clr;
      v.pat = pat; v.msk = 4'b1111; v.ed = ed; v.ec = ec; v.ea = ea;
      return v;
   endfunction

   task automatic add(logic rst, logic din, logic valid, logic ov, logic ld, logic clr,
                      logic [3:0] pat, logic ed, logic [7:0] ec, logic ea);
      vq.push_back(mk(rst, din, valid, ov, ld, clr, pat, ed, ec, ea));
   endtask

   // Reset vector: expects all outputs cleared.
   task automatic add_rst();
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0);
   endtask

   // Accepted data bit, no config activity.
   task automatic add_bit(logic din, logic ov, logic ed, logic [7:0] ec, logic ea);
      add(1'b0, din, 1'b1, ov, 1'b0, 1'b0, 4'b0000, ed, ec, ea);
   endtask

   task automatic check(string name, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive one vector, clock once, compare outputs 1 time unit after the edge.
   task automatic apply(vec_t v, string tag);
      reset           = v.rst;
      bus.din         = v.din;
      bus.din_valid   = v.valid;
      bus.overlap_en  = v.ov;
      bus.cfg_load    = v.ld;
      bus.cnt_clr     = v.clr;
      bus.cfg_pattern = v.pat;
`ifdef PATTERN_MASK_EN
      bus.cfg_mask    = v.msk;
`endif
      @(posedge clk);
      #1;
      check({tag, " detect"}, int'(bus.detect), int'(v.ed));
      check({tag, " count"},  int'(bus.match_count), int'(v.ec));
      check({tag, " armed"},  int'(bus.armed), int'(v.ea));
   endtask

   initial begin
      vec_t v;
      int   exp_cnt;

      reset = 1'b1;
      bus.din = 1'b0; bus.din_valid = 1'b0; bus.overlap_en = 1'b1;
      bus.cfg_load = 1'b0; bus.cnt_clr = 1'b0; bus.cfg_pattern = 4'b0000;
`ifdef PATTERN_MASK_EN
      bus.cfg_mask = 4'b1111;
`endif

      // Overlapping: 1,0,1,1,0,1,1 -> detect on bits 4 and 7.
      add_rst();
      add_bit(1, 1, 0, 0, 0); add_bit(0, 1, 0, 0, 0); add_bit(1, 1, 0, 0, 0);
      add_bit(1, 1, 1, 1, 1); add_bit(0, 1, 0, 1, 1); add_bit(1, 1, 0, 1, 1);
      add_bit(1, 1, 1, 2, 1);
      // Non-overlapping: same stream -> only bit 4, armed drops after the hit.
      add_rst();
      add_bit(1, 0, 0, 0, 0); add_bit(0, 0, 0, 0, 0); add_bit(1, 0, 0, 0, 0);
      add_bit(1, 0, 1, 1, 0); add_bit(0, 0, 0, 1, 0); add_bit(1, 0, 0, 1, 0);
      add_bit(1, 0, 0, 1, 0);
      // Gapped stream: invalid cycles carry din=1 and must be ignored.
      add_rst();
      add_bit(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
      add_bit(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
      add_bit(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
      add_bit(1, 1, 1, 1, 1);
      add(0, 1, 0, 1, 0, 0, 4'b0000, 0, 1, 1);
      // Reload to 0110 with a same-cycle valid bit (discarded), count kept.
      add(0, 1, 1, 1, 1, 0, 4'b0110, 0, 1, 0);
      add_bit(0, 1, 0, 1, 0); add_bit(1, 1, 0, 1, 0); add_bit(1, 1, 0, 1, 0);
      add_bit(0, 1, 1, 2, 1);
      add_bit(1, 1, 0, 2, 1); add_bit(0, 1, 0, 2, 1); add_bit(1, 1, 0, 2, 1);
      add_bit(1, 1, 0, 2, 1);
      // Reset mid-stream restores 1011 and clears the partial window.
      add_rst();
      add_bit(1, 1, 0, 0, 0); add_bit(0, 1, 0, 0, 0); add_bit(1, 1, 0, 0, 0);
      add_rst();
      add_bit(1, 1, 0, 0, 0); add_bit(0, 1, 0, 0, 0); add_bit(1, 1, 0, 0, 0);
      add_bit(1, 1, 1, 1, 1);

      foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

      // Saturation with pattern 1111 and overlapping hits.
      apply(mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0), "sat rst");
      apply(mk(0, 0, 0, 1, 1, 0, 4'b1111, 0, 0, 0), "sat load");
      for (int i = 0; i < 3; i++) apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "sat fill");
      exp_cnt = 0;
      for (int i = 0; i < 260; i++) begin
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 1, 8'(exp_cnt), 1), $sformatf("sat hit%0d", i));
      end
      apply(mk(0, 1, 1, 1, 0, 1, 4'b0000, 1, 0, 1), "clr with hit");
      apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 1, 1, 1), "hit after clr");
      apply(mk(0, 1, 0, 1, 0, 0, 4'b0000, 0, 1, 1), "idle after hit");

`ifdef PATTERN_MASK_EN
      // Mask 1001 / pattern 1001 matches any 1xx1 window.
      apply(mk(1, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0), "mask rst");
      v = mk(0, 0, 0, 1, 1, 0, 4'b1001, 0, 0, 0);
      v.msk = 4'b1001;
      apply(v, "mask load");
      apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "mask b1");
      apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "mask b2");
      apply(mk(0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0), "mask b3");
      apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 1, 1, 1), "mask b4");
      apply(mk(0, 0, 1, 1, 0, 0, 4'b0000, 0, 1, 1), "mask b5");
      apply(mk(0, 0, 1, 1, 0, 0, 4'b0000, 0, 1, 1), "mask b6");
      apply(mk(0, 1, 1, 1, 0, 0, 4'b0000, 1, 2, 1), "mask b7");
`else
      v = mk(0, 0, 0, 1, 0, 0, 4'b0000, 0, 1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
